// File: rtl/quidditch_pkg.sv
// Shared game definitions: FSM state codes, winner codes, BCD score width
// and BCD helper functions. Also used by the score display logic.
package quidditch_pkg;

    localparam int SCORE_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PLAY  = 2'd1,
        ST_PAUSE = 2'd2,
        ST_OVER  = 2'd3
    } state_t;

    localparam logic [1:0] WIN_NONE = 2'b00;
    localparam logic [1:0] WIN_T1   = 2'b01;
    localparam logic [1:0] WIN_T2   = 2'b10;
    localparam logic [1:0] WIN_TIE  = 2'b11;

    // Two-digit BCD increment; 99 holds at 99.
    function automatic logic [SCORE_W-1:0] bcd_inc(input logic [SCORE_W-1:0] v);
        logic [SCORE_W-1:0] r;
        if (v == 8'h99)
            r = v;
        else if (v[3:0] == 4'd9)
            r = {v[7:4] + 4'd1, 4'd0};
        else
            r = {v[7:4], v[3:0] + 4'd1};
        return r;
    endfunction

    // Binary 0..99 to two-digit BCD, used for elaboration-time constants.
    function automatic logic [SCORE_W-1:0] to_bcd(input int unsigned v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    // Both scores are BCD, so a plain unsigned compare orders them correctly.
    function automatic logic [1:0] winner_of(input logic [SCORE_W-1:0] a,
                                             input logic [SCORE_W-1:0] b);
        logic [1:0] w;
        if (a > b)
            w = WIN_T1;
        else if (b > a)
            w = WIN_T2;
        else
            w = WIN_TIE;
        return w;
    endfunction

endpackage

// File: rtl/score_keeper_bcd_counter2.sv
// Two-digit BCD counter with synchronous clear (priority over increment)
// and saturation at 99.
module bcd_counter2
    import quidditch_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               i_clr,
    input  logic               i_inc,
    output logic [SCORE_W-1:0] o_count
);

    logic [SCORE_W-1:0] r_count;

    // Count register: clear wins over increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_count <= '0;
        else if (i_clr)
            r_count <= '0;
        else if (i_inc)
            r_count <= bcd_inc(r_count);
    end

    assign o_count = r_count;

endmodule

// File: rtl/score_keeper.sv
// Turns ball-controller goal levels into BCD team scores, sequences rounds
// (post-goal pause, restart pulse) and declares the match winner.
module score_keeper
    import quidditch_pkg::*;
#(
    parameter int unsigned WIN_SCORE    = 7,
    parameter int unsigned PAUSE_CYCLES = 50000000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_button,
    input  logic               score_to_team1,
    input  logic               score_to_team2,
    output logic [SCORE_W-1:0] team1_score,
    output logic [SCORE_W-1:0] team2_score,
    output logic               round_reset,
    output logic               game_over,
    output logic [1:0]         winner,
    output logic [1:0]         state_out
);

    localparam logic [SCORE_W-1:0] WIN_BCD    = to_bcd(WIN_SCORE);
    localparam logic [31:0]        PAUSE_LAST = 32'(PAUSE_CYCLES - 1);

    logic         r_start_meta;
    logic         r_start_sync;
    logic         r_start_prev;
    logic         r_goal1_prev;
    logic         r_goal2_prev;
    state_t       r_state;
    logic         r_round_reset;
    logic         r_game_over;
    logic [1:0]   r_winner;
    logic [31:0]  r_pause_cnt;

    logic               w_start_rise;
    logic               w_goal1_rise;
    logic               w_goal2_rise;
    logic               w_inc1;
    logic               w_inc2;
    logic               w_clr;
    logic [SCORE_W-1:0] w_t1_next;
    logic [SCORE_W-1:0] w_t2_next;
    logic               w_win;

    // Start button synchronizer plus edge-detect history; goal level history.
    // Goal history updates in every state so a level held through PAUSE/OVER
    // cannot produce a second edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_start_meta <= 1'b0;
            r_start_sync <= 1'b0;
            r_start_prev <= 1'b0;
            r_goal1_prev <= 1'b0;
            r_goal2_prev <= 1'b0;
        end else begin
            r_start_meta <= start_button;
            r_start_sync <= r_start_meta;
            r_start_prev <= r_start_sync;
            r_goal1_prev <= score_to_team1;
            r_goal2_prev <= score_to_team2;
        end
    end

    assign w_start_rise = r_start_sync & ~r_start_prev;
    assign w_goal1_rise = score_to_team1 & ~r_goal1_prev;
    assign w_goal2_rise = score_to_team2 & ~r_goal2_prev;

    // Counter controls and look-ahead of the post-increment scores for the win test.
    always_comb begin
        w_inc1    = (r_state == ST_PLAY) && w_goal1_rise;
        w_inc2    = (r_state == ST_PLAY) && w_goal2_rise;
        w_clr     = (r_state == ST_IDLE) || ((r_state == ST_OVER) && w_start_rise);
        w_t1_next = w_inc1 ? bcd_inc(team1_score) : team1_score;
        w_t2_next = w_inc2 ? bcd_inc(team2_score) : team2_score;
        w_win     = (w_t1_next >= WIN_BCD) || (w_t2_next >= WIN_BCD);
    end

    bcd_counter2 u_team1 (
        .clk     (clk),
        .rst     (rst),
        .i_clr   (w_clr),
        .i_inc   (w_inc1),
        .o_count (team1_score)
    );

    bcd_counter2 u_team2 (
        .clk     (clk),
        .rst     (rst),
        .i_clr   (w_clr),
        .i_inc   (w_inc2),
        .o_count (team2_score)
    );

    // Round sequencing FSM with registered round_reset, game_over and winner.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_round_reset <= 1'b0;
            r_game_over   <= 1'b0;
            r_winner      <= WIN_NONE;
            r_pause_cnt   <= '0;
        end else begin
            r_round_reset <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_start_rise) begin
                        r_state       <= ST_PLAY;
                        r_round_reset <= 1'b1;
                    end
                end
                ST_PLAY: begin
                    if (w_inc1 || w_inc2) begin
                        if (w_win) begin
                            r_state     <= ST_OVER;
                            r_game_over <= 1'b1;
                            r_winner    <= winner_of(w_t1_next, w_t2_next);
                        end else begin
                            r_state     <= ST_PAUSE;
                            r_pause_cnt <= '0;
                        end
                    end
                end
                ST_PAUSE: begin
                    if (r_pause_cnt == PAUSE_LAST) begin
                        r_state       <= ST_PLAY;
                        r_round_reset <= 1'b1;
                        r_pause_cnt   <= '0;
                    end else begin
                        r_pause_cnt <= r_pause_cnt + 32'd1;
                    end
                end
                ST_OVER: begin
                    if (w_start_rise) begin
                        r_state       <= ST_PLAY;
                        r_round_reset <= 1'b1;
                        r_game_over   <= 1'b0;
                        r_winner      <= WIN_NONE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign round_reset = r_round_reset;
    assign game_over   = r_game_over;
    assign winner      = r_winner;
    assign state_out   = r_state;

endmodule

// File: tb/tb_score_keeper.sv
// Directed bench for score_keeper. Instance a: WIN_SCORE=12, PAUSE_CYCLES=4
// (pause timing, held goal level, BCD carry). Instance b: WIN_SCORE=2,
// PAUSE_CYCLES=4 (tie win, restart from OVER, ignored edges, reset mid-pause).
module tb_score_keeper;

    logic       clk;
    logic       rst;
    logic       start_button;
    logic       a_goal1, a_goal2, b_goal1, b_goal2;
    logic [7:0] a_t1, a_t2, b_t1, b_t2;
    logic       a_rr, a_go, b_rr, b_go;
    logic [1:0] a_win, a_st, b_win, b_st;

    int errors = 0;
    int checks = 0;
    logic [7:0] exp_q[$];

    score_keeper #(.WIN_SCORE(12), .PAUSE_CYCLES(4)) dut_a (
        .clk(clk), .rst(rst), .start_button(start_button),
        .score_to_team1(a_goal1), .score_to_team2(a_goal2),
        .team1_score(a_t1), .team2_score(a_t2),
        .round_reset(a_rr), .game_over(a_go), .winner(a_win), .state_out(a_st)
    );

    score_keeper #(.WIN_SCORE(2), .PAUSE_CYCLES(4)) dut_b (
        .clk(clk), .rst(rst), .start_button(start_button),
        .score_to_team1(b_goal1), .score_to_team2(b_goal2),
        .team1_score(b_t1), .team2_score(b_t2),
        .round_reset(b_rr), .game_over(b_go), .winner(b_win), .state_out(b_st)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge, then settle 1 time unit before sampling/driving.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1;
        start_button = 1'b0;
        a_goal1 = 1'b0; a_goal2 = 1'b0; b_goal1 = 1'b0; b_goal2 = 1'b0;
        for (int i = 1; i <= 9; i++) exp_q.push_back(8'(i));
        exp_q.push_back(8'h10);

        // Reset values
        repeat (3) step();
        check("rst_state", 8'(a_st), 8'd0);
        check("rst_t1", a_t1, 8'h00);
        check("rst_t2", a_t2, 8'h00);
        check("rst_rr", 8'(a_rr), 8'd0);
        check("rst_go", 8'(a_go), 8'd0);
        check("rst_win", 8'(a_win), 8'd0);
        rst = 1'b0;
        step();

        // Start press: round_reset on the 3rd edge after the button rises
        start_button = 1'b1;
        step();
        check("start_e1_state", 8'(a_st), 8'd0);
        step();
        check("start_e2_state", 8'(a_st), 8'd0);
        check("start_e2_rr", 8'(a_rr), 8'd0);
        step();
        check("start_e3_state", 8'(a_st), 8'd1);
        check("start_e3_rr", 8'(a_rr), 8'd1);
        check("start_e3_t1", a_t1, 8'h00);
        check("start_e3_b_state", 8'(b_st), 8'd1);
        step();
        check("start_e4_rr", 8'(a_rr), 8'd0);
        start_button = 1'b0;
        step();

        // Team1 goal held high for 10 cycles: one count, PAUSE for 4 cycles
        a_goal1 = 1'b1;
        step();
        check("goal1_t1", a_t1, 8'h01);
        check("goal1_state", 8'(a_st), 8'd2);
        repeat (3) step();
        check("pause3_state", 8'(a_st), 8'd2);
        check("pause3_rr", 8'(a_rr), 8'd0);
        step();
        check("pause4_state", 8'(a_st), 8'd1);
        check("pause4_rr", 8'(a_rr), 8'd1);
        repeat (5) step();
        check("held_t1", a_t1, 8'h01);
        check("held_state", 8'(a_st), 8'd1);
        a_goal1 = 1'b0;
        step();

        // Ten team2 goals: 01..09 then BCD carry to 10
        for (int g = 0; g < 10; g++) begin
            a_goal2 = 1'b1;
            step();
            check("t2_seq", a_t2, exp_q.pop_front());
            check("t2_seq_state", 8'(a_st), 8'd2);
            a_goal2 = 1'b0;
            repeat (4) step();
        end
        check("t2_end_state", 8'(a_st), 8'd1);
        check("t2_end_t1", a_t1, 8'h01);
        check("t2_end_go", 8'(a_go), 8'd0);

        // Instance b: 1-1, then simultaneous goals reach WIN_SCORE=2 -> tie
        b_goal1 = 1'b1;
        step();
        check("b_t1_01", b_t1, 8'h01);
        b_goal1 = 1'b0;
        repeat (4) step();
        b_goal2 = 1'b1;
        step();
        check("b_t2_01", b_t2, 8'h01);
        b_goal2 = 1'b0;
        repeat (4) step();
        check("b_play", 8'(b_st), 8'd1);
        b_goal1 = 1'b1;
        b_goal2 = 1'b1;
        step();
        check("tie_t1", b_t1, 8'h02);
        check("tie_t2", b_t2, 8'h02);
        check("tie_state", 8'(b_st), 8'd3);
        check("tie_go", 8'(b_go), 8'd1);
        check("tie_win", 8'(b_win), 8'd3);
        check("tie_rr", 8'(b_rr), 8'd0);
        b_goal1 = 1'b0;
        b_goal2 = 1'b0;
        step();

        // Goal edge in OVER is ignored
        b_goal1 = 1'b1;
        step();
        check("over_goal_t1", b_t1, 8'h02);
        check("over_goal_state", 8'(b_st), 8'd3);
        b_goal1 = 1'b0;
        step();

        // Start from OVER: clear scores and winner, round_reset, back to PLAY
        start_button = 1'b1;
        step();
        step();
        check("restart_e2_state", 8'(b_st), 8'd3);
        check("restart_e2_go", 8'(b_go), 8'd1);
        step();
        check("restart_state", 8'(b_st), 8'd1);
        check("restart_rr", 8'(b_rr), 8'd1);
        check("restart_t1", b_t1, 8'h00);
        check("restart_t2", b_t2, 8'h00);
        check("restart_win", 8'(b_win), 8'd0);
        check("restart_go", 8'(b_go), 8'd0);
        check("a_play_start_ignored", 8'(a_st), 8'd1);
        check("a_play_no_rr", 8'(a_rr), 8'd0);
        step();
        check("restart_rr_off", 8'(b_rr), 8'd0);
        start_button = 1'b0;
        step();

        // Goal edge in PAUSE is ignored, then reset mid-count
        b_goal1 = 1'b1;
        step();
        check("pp_t1", b_t1, 8'h01);
        check("pp_state", 8'(b_st), 8'd2);
        b_goal1 = 1'b0;
        step();
        b_goal2 = 1'b1;
        step();
        check("pp_t2_ignored", b_t2, 8'h00);
        check("pp_state2", 8'(b_st), 8'd2);
        rst = 1'b1;
        #1;
        check("mid_rst_state", 8'(b_st), 8'd0);
        check("mid_rst_t1", b_t1, 8'h00);
        check("mid_rst_rr", 8'(b_rr), 8'd0);
        check("mid_rst_go", 8'(b_go), 8'd0);
        check("mid_rst_win", 8'(b_win), 8'd0);
        check("mid_rst_a_t2", a_t2, 8'h00);
        check("mid_rst_a_state", 8'(a_st), 8'd0);
        b_goal2 = 1'b0;
        for (int c = 0; c < 5; c++) begin
            step();
            check("rst_hold_rr", 8'(b_rr), 8'd0);
        end
        rst = 1'b0;
        repeat (6) step();
        check("post_rst_state", 8'(b_st), 8'd0);
        check("post_rst_rr", 8'(b_rr), 8'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
